// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if -- word handshake between user logic and the UART transmitter.
//
// Signals:
//   tx_valid  : master -> slave, data_in holds a word to send
//   data_in   : master -> slave, word to transmit (DATA_BITS wide)
//   tx_ready  : slave  -> master, transmitter can take a word this cycle
//
// A word moves on any rising clock edge where tx_valid && tx_ready.
// -----------------------------------------------------------------------------
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] data_in;
    logic                 tx_ready;

    modport master (
        output tx_valid,
        output data_in,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  data_in,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- parameterised UART transmitter.
//
// Serialises one word per frame, LSB first: start bit (0), DATA_BITS data
// bits, optional parity bit, STOP_BIT stop bits (1). Every bit, the start bit
// included, lasts exactly BAUD_DIV clock cycles.
//
// Parameters:
//   BAUD_DIV    : clock cycles per bit (>= 2)
//   DATA_BITS   : data bits per frame (5..9)
//   PARITY_TYPE : 0 = none, 1 = even, 2 = odd, anything else = none
//   STOP_BIT    : number of stop bits (1..2)
//
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous active-low reset (aborts a frame, tx goes high)
//   bus      : uart_tx_if.slave -- tx_valid / data_in in, tx_ready out
//   tx       : serial line, idle high, registered
//   busy     : a frame is on the line
//   tx_done  : one-cycle pulse at the end of the last stop bit
//
// Build option UART_TX_BUF_EN: adds a one-entry holding register in front of
// the shift register. tx_ready then means "holding register empty", so the
// next word can be taken during a frame and is started with no idle gap.
// Without it, tx_ready is low for the whole frame and frames are separated
// by at least one idle cycle.
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int BAUD_DIV    = 434,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_TYPE = 0,
    parameter int STOP_BIT    = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_tx_if.slave bus,
    output logic     tx,
    output logic     busy,
    output logic     tx_done
);

    localparam int BW = (BAUD_DIV > 32'sd1) ? $clog2(BAUD_DIV) : 32'sd1;
    localparam int CW = $clog2(DATA_BITS) + 32'sd1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 32'sd1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 32'sd1);
    // Only one or two stop bits exist, so a single-bit stop counter suffices.
    localparam logic          STOP_LAST = (STOP_BIT == 32'sd2) ? 1'b1 : 1'b0;
    localparam bit            PAR_EN    = (PARITY_TYPE == 32'sd1) || (PARITY_TYPE == 32'sd2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Parity bit of a word as it goes on the line.
    function automatic logic parity_f(input logic [DATA_BITS-1:0] word);
        logic p;
        case (PARITY_TYPE)
            32'sd1:  p = ^word;
            32'sd2:  p = ~^word;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    state_t               state_r;
    logic                 tx_r;
    logic                 busy_r;
    logic                 tx_done_r;
    logic                 tx_ready_r;
    logic [BW-1:0]        baud_cnt_r;
    logic [CW-1:0]        bit_cnt_r;
    logic                 stop_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 parity_r;

    logic                 accept_s;
    logic                 baud_wrap_s;
    logic                 frame_end_s;
    logic                 load_s;
    logic [DATA_BITS-1:0] load_data_s;

`ifdef UART_TX_BUF_EN
    logic                 hold_full_r;
    logic [DATA_BITS-1:0] hold_data_r;
    logic                 hold_write_s;
`endif

    assign tx           = tx_r;
    assign busy         = busy_r;
    assign tx_done      = tx_done_r;
    assign bus.tx_ready = tx_ready_r;

    // Handshake, bit timing and decision of which word (if any) starts a frame.
    always_comb begin
        accept_s    = bus.tx_valid && tx_ready_r;
        baud_wrap_s = (baud_cnt_r == BAUD_LAST);
        frame_end_s = (state_r == STOP) && baud_wrap_s && (stop_cnt_r == STOP_LAST);
`ifdef UART_TX_BUF_EN
        // While idle a word goes straight to the shift register; during a
        // frame it waits in the holding register.
        hold_write_s = accept_s && (state_r != IDLE);
        if (hold_full_r && ((state_r == IDLE) || frame_end_s)) begin
            load_s      = 1'b1;
            load_data_s = hold_data_r;
        end else if (accept_s && (state_r == IDLE)) begin
            load_s      = 1'b1;
            load_data_s = bus.data_in;
        end else begin
            load_s      = 1'b0;
            load_data_s = bus.data_in;
        end
`else
        load_s      = accept_s && (state_r == IDLE);
        load_data_s = bus.data_in;
`endif
    end

`ifdef UART_TX_BUF_EN
    // Holding register; tx_ready mirrors "holding register empty".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full_r <= 1'b0;
            hold_data_r <= '0;
            tx_ready_r  <= 1'b1;
        end else if (hold_write_s) begin
            hold_full_r <= 1'b1;
            hold_data_r <= bus.data_in;
            tx_ready_r  <= 1'b0;
        end else if (load_s && hold_full_r) begin
            hold_full_r <= 1'b0;
            hold_data_r <= hold_data_r;
            tx_ready_r  <= 1'b1;
        end else begin
            hold_full_r <= hold_full_r;
            hold_data_r <= hold_data_r;
            tx_ready_r  <= tx_ready_r;
        end
    end
`else
    // tx_ready drops when a frame starts and returns at the tx_done edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ready_r <= 1'b1;
        end else if (load_s) begin
            tx_ready_r <= 1'b0;
        end else if (frame_end_s) begin
            tx_ready_r <= 1'b1;
        end else begin
            tx_ready_r <= tx_ready_r;
        end
    end
`endif

    // Frame sequencer: drives tx bit by bit and generates busy / tx_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            tx_done_r  <= 1'b0;
            baud_cnt_r <= '0;
            bit_cnt_r  <= '0;
            stop_cnt_r <= 1'b0;
            shift_r    <= '0;
            parity_r   <= 1'b0;
        end else begin
            tx_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    baud_cnt_r <= '0;
                    if (load_s) begin
                        state_r  <= START;
                        tx_r     <= 1'b0;
                        busy_r   <= 1'b1;
                        shift_r  <= load_data_s;
                        parity_r <= parity_f(load_data_s);
                    end else begin
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                START: begin
                    if (baud_wrap_s) begin
                        baud_cnt_r <= '0;
                        state_r    <= DATA;
                        tx_r       <= shift_r[0];
                        shift_r    <= {1'b0, shift_r[DATA_BITS-1:1]};
                        bit_cnt_r  <= '0;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_wrap_s) begin
                        baud_cnt_r <= '0;
                        if (bit_cnt_r == BIT_LAST) begin
                            if (PAR_EN) begin
                                state_r <= PARITY;
                                tx_r    <= parity_r;
                            end else begin
                                state_r    <= STOP;
                                tx_r       <= 1'b1;
                                stop_cnt_r <= 1'b0;
                            end
                        end else begin
                            tx_r      <= shift_r[0];
                            shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
                            bit_cnt_r <= bit_cnt_r + 1'b1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
                PARITY: begin
                    if (baud_wrap_s) begin
                        baud_cnt_r <= '0;
                        state_r    <= STOP;
                        tx_r       <= 1'b1;
                        stop_cnt_r <= 1'b0;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_wrap_s) begin
                        baud_cnt_r <= '0;
                        if (stop_cnt_r == STOP_LAST) begin
                            tx_done_r <= 1'b1;
                            // A buffered word starts right at this edge.
                            if (load_s) begin
                                state_r  <= START;
                                tx_r     <= 1'b0;
                                busy_r   <= 1'b1;
                                shift_r  <= load_data_s;
                                parity_r <= parity_f(load_data_s);
                            end else begin
                                state_r <= IDLE;
                                tx_r    <= 1'b1;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            stop_cnt_r <= stop_cnt_r + 1'b1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    tx_r       <= 1'b1;
                    busy_r     <= 1'b0;
                    baud_cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx.
// Four instances share clk/rst_n: 0 = 8N1, 1 = 8E1, 2 = 8O1, 3 = 8N2, all with
// BAUD_DIV = 4. The line of every instance is logged each cycle and decoded
// by a simple receiver model; expected frames come from the frame rules.
// -----------------------------------------------------------------------------
module tb_uart_tx;
    localparam int B    = 4;
    localparam int MAXC = 8192;

    typedef struct {
        int         k;
        logic [7:0] d;
        int         nb;
        logic [11:0] bits;
    } vec_t;

    typedef struct {
        int         s;
        logic [7:0] w;
        logic       p;
        logic       ok;
    } frm_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc   = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    logic [3:0] v_d   = 4'b0000;
    logic [7:0] d_d [4];
    logic       tx_log   [4][MAXC];
    logic       done_log [4][MAXC];
    logic [7:0] drv [MAXC];
    frm_t       rxq [$];
    vec_t       vt [8];

    wire tx0, tx1, tx2, tx3, busy0, busy1, busy2, busy3, done0, done1, done2, done3;

    always #5 clk = ~clk;

    uart_tx_if #(.DATA_BITS(8)) bus0 ();
    uart_tx_if #(.DATA_BITS(8)) bus1 ();
    uart_tx_if #(.DATA_BITS(8)) bus2 ();
    uart_tx_if #(.DATA_BITS(8)) bus3 ();
    assign bus0.tx_valid = v_d[0];
    assign bus1.tx_valid = v_d[1];
    assign bus2.tx_valid = v_d[2];
    assign bus3.tx_valid = v_d[3];
    assign bus0.data_in  = d_d[0];
    assign bus1.data_in  = d_d[1];
    assign bus2.data_in  = d_d[2];
    assign bus3.data_in  = d_d[3];

    uart_tx #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY_TYPE(0), .STOP_BIT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .tx(tx0), .busy(busy0), .tx_done(done0));
    uart_tx #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY_TYPE(1), .STOP_BIT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .tx(tx1), .busy(busy1), .tx_done(done1));
    uart_tx #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY_TYPE(2), .STOP_BIT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .tx(tx2), .busy(busy2), .tx_done(done2));
    uart_tx #(.BAUD_DIV(B), .DATA_BITS(8), .PARITY_TYPE(0), .STOP_BIT(2)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .tx(tx3), .busy(busy3), .tx_done(done3));

    wire [3:0] tx_w   = {tx3, tx2, tx1, tx0};
    wire [3:0] busy_w = {busy3, busy2, busy1, busy0};
    wire [3:0] done_w = {done3, done2, done1, done0};
    wire [3:0] rdy_w  = {bus3.tx_ready, bus2.tx_ready, bus1.tx_ready, bus0.tx_ready};

    // Cycle index: interval c lies between posedge c and posedge c+1.
    always @(posedge clk) cyc = cyc + 1;

    // Line logger, sampled mid-cycle.
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            for (int k = 0; k < 4; k++) begin
                tx_log[k][cyc]   = tx_w[k];
                done_log[k][cyc] = done_w[k];
            end
        end
    end

    function automatic int ptype(input int k);
        case (k)
            1:       return 1;
            2:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int nstop(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    function automatic int flen(input int k);
        return 9 + ((ptype(k) != 0) ? 1 : 0) + nstop(k);
    endfunction

    // Reference parity: count ones, then choose the bit that makes the
    // total even (even parity) or odd (odd parity).
    function automatic logic exp_par(input logic [7:0] w, input int pt);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones = ones + int'(w[i]);
        if (pt == 1) return ((ones % 2) == 1);
        else if (pt == 2) return ((ones % 2) == 0);
        else return 1'b0;
    endfunction

    // Receiver model: finds start bits in the logged line and samples each
    // bit in its middle.
    function automatic void decode(input int k, input int lo, input int hi_in);
        int c, n, hi;
        frm_t f;
        n  = flen(k);
        hi = (hi_in < MAXC) ? hi_in : MAXC - 1;
        rxq = {};
        c = lo;
        while (c + n * B <= hi) begin
            if (tx_log[k][c] == 1'b0) begin
                f.s  = c;
                f.ok = (tx_log[k][c + B / 2] == 1'b0);
                for (int i = 0; i < 8; i++) f.w[i] = tx_log[k][c + (1 + i) * B + B / 2];
                f.p = (ptype(k) != 0) ? tx_log[k][c + 9 * B + B / 2] : 1'b0;
                for (int j = 0; j < nstop(k); j++)
                    if (tx_log[k][c + (n - nstop(k) + j) * B + B / 2] != 1'b1) f.ok = 1'b0;
                rxq.push_back(f);
                c = c + n * B;
            end else begin
                c = c + 1;
            end
        end
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    endtask

    // Offers a word and returns the interval in which its frame starts
    // (valid when the transmitter is idle), or -1 on timeout.
    task automatic send_word(input int k, input logic [7:0] w, output int acc);
        acc = -1;
        @(negedge clk);
        v_d[k] = 1'b1;
        d_d[k] = w;
        for (int t = 0; t < 400 && acc < 0; t++) begin
            if (rdy_w[k]) acc = cyc + 1;
            @(negedge clk);
        end
        v_d[k] = 1'b0;
        d_d[k] = 8'($urandom);
        if (acc < 0) begin
            n_chk = n_chk + 1;
            $display("FAIL send_timeout dut%0d: tx_ready not seen within 400 cycles", k);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int acc, dt;
        logic [11:0] act;
        send_word(v.k, v.d, acc);
        if (acc >= 0) begin
`ifdef UART_TX_BUF_EN
            check($sformatf("ready_in_frame dut%0d", v.k), int'(rdy_w[v.k]), 1);
`else
            check($sformatf("ready_in_frame dut%0d", v.k), int'(rdy_w[v.k]), 0);
`endif
            check($sformatf("busy_in_frame dut%0d", v.k), int'(busy_w[v.k]), 1);
            repeat (v.nb * B + 3) @(negedge clk);
            act = '0;
            for (int i = 0; i < v.nb; i++) act[i] = tx_log[v.k][acc + i * B + B / 2];
            check($sformatf("bits dut%0d d=%02h", v.k, v.d), int'(act), int'(v.bits));
            dt = -1;
            for (int c = acc; c <= acc + v.nb * B + 2; c++)
                if (done_log[v.k][c] && dt < 0) dt = c - acc;
            check($sformatf("done_time dut%0d d=%02h", v.k, v.d), dt, v.nb * B);
        end
    endtask

    task automatic rand_run(input int k, input int nw);
        logic [7:0] sent [$];
        logic [7:0] w;
        int acc, lo, n, m;
        n  = flen(k);
        lo = cyc + 1;
        for (int i = 0; i < nw; i++) begin
            w = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_word(k, w, acc);
            if (acc >= 0) sent.push_back(w);
        end
        repeat (3 * n * B) @(negedge clk);
        decode(k, lo, cyc - 1);
        check($sformatf("rand_count dut%0d", k), rxq.size(), sent.size());
        m = (rxq.size() < sent.size()) ? rxq.size() : sent.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("rand_word dut%0d #%0d", k, i), int'(rxq[i].w), int'(sent[i]));
            check($sformatf("rand_frame dut%0d #%0d", k, i), int'(rxq[i].ok), 1);
            if (ptype(k) != 0)
                check($sformatf("rand_parity dut%0d #%0d", k, i), int'(rxq[i].p),
                      int'(exp_par(sent[i], ptype(k))));
            check($sformatf("rand_done dut%0d #%0d", k, i),
                  int'(done_log[k][rxq[i].s + n * B]), 1);
        end
    endtask

    // tx_valid held high with fresh data every cycle on instance 0.
    task automatic b2b();
        int c0, cend, nb, a, s, j, m;
        int exp_s [$];
        logic [7:0] exp_w [$];
        nb = flen(0) * B;
        @(negedge clk);
        c0 = cyc + 1;
        v_d[0] = 1'b1;
        for (int i = 0; i < 128; i++) begin
            d_d[0] = 8'($urandom);
            drv[cyc + 1] = d_d[0];
            @(negedge clk);
        end
        v_d[0] = 1'b0;
        cend = cyc + 1;
        j = 0;
        a = c0;
        while (a < cend) begin
`ifdef UART_TX_BUF_EN
            a = (j == 0) ? c0 : c0 + (j - 1) * nb + 1;
            s = c0 + j * nb;
`else
            a = c0 + j * (nb + 1);
            s = a;
`endif
            if (a < cend) begin
                exp_s.push_back(s);
                exp_w.push_back(drv[a]);
            end
            j = j + 1;
        end
        repeat (6 * nb) @(negedge clk);
        decode(0, c0, cyc - 1);
        check("b2b_count", rxq.size(), exp_s.size());
        m = (rxq.size() < exp_s.size()) ? rxq.size() : exp_s.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("b2b_start #%0d", i), rxq[i].s - c0, exp_s[i] - c0);
            check($sformatf("b2b_word #%0d", i), int'(rxq[i].w), int'(exp_w[i]));
        end
    endtask

    initial begin
        int acc, lo, lows, dones;
        vt[0] = '{0, 8'hA5, 10, 12'b00_1101001010};
        vt[1] = '{1, 8'h07, 11, 12'b0_11000001110};
        vt[2] = '{2, 8'h07, 11, 12'b0_10000001110};
        vt[3] = '{3, 8'h00, 11, 12'b0_11000000000};
        vt[4] = '{0, 8'h00, 10, 12'b00_1000000000};
        vt[5] = '{0, 8'hFF, 10, 12'b00_1111111110};
        vt[6] = '{1, 8'h00, 11, 12'b0_10000000000};
        vt[7] = '{2, 8'h00, 11, 12'b0_11000000000};
        for (int k = 0; k < 4; k++) d_d[k] = 8'h00;

        // Reset and idle behaviour.
        repeat (3) @(negedge clk);
        check("tx_in_reset", int'(tx_w), 15);
        rst_n = 1'b1;
        @(negedge clk);
        check("tx_after_reset", int'(tx_w), 15);
        check("ready_after_reset", int'(rdy_w), 15);
        check("busy_after_reset", int'(busy_w), 0);
        check("done_after_reset", int'(done_w), 0);
        lows  = 0;
        dones = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_w != 4'b0000) dones = dones + 1;
            if (tx_w != 4'b1111) lows = lows + 1;
        end
        check("idle_no_done", dones, 0);
        check("idle_tx_high", lows, 0);

        // Directed frames.
        for (int i = 0; i < 8; i++) run_vec(vt[i]);

        // Random words against the receiver model.
        for (int k = 0; k < 4; k++) rand_run(k, 6);

        // Back-to-back with tx_valid held high.
        b2b();

        // Reset during data bit 3, then a clean frame.
        send_word(0, 8'h00, acc);
        if (acc >= 0) begin
            while (cyc < acc + 4 * B + 1) @(negedge clk);
            check("tx_low_before_abort", int'(tx_w[0]), 0);
            #2 rst_n = 1'b0;
            #1;
            check("abort_tx_high", int'(tx_w[0]), 1);
            check("abort_ready", int'(rdy_w[0]), 1);
            check("abort_busy", int'(busy_w[0]), 0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            lo = cyc + 1;
            repeat (3 * flen(0) * B) @(negedge clk);
            lows  = 0;
            dones = 0;
            for (int c = lo; c < cyc; c++) begin
                if (!tx_log[0][c]) lows = lows + 1;
                if (done_log[0][c]) dones = dones + 1;
            end
            check("abort_no_resume_tx", lows, 0);
            check("abort_no_resume_done", dones, 0);
            lo = cyc + 1;
            send_word(0, 8'h3C, acc);
            repeat (flen(0) * B + 4) @(negedge clk);
            decode(0, lo, cyc - 1);
            check("post_reset_count", rxq.size(), 1);
            if (rxq.size() > 0) begin
                check("post_reset_word", int'(rxq[0].w), 8'h3C);
                check("post_reset_frame", int'(rxq[0].ok), 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time, %0d/%0d checks passed",
                 n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Parameterised UART transmitter. It is the transmit-side counterpart of the board's UART receiver and uses the same frame format and parameter set.
- It accepts a data word over a valid/ready handshake and serialises it LSB-first on `tx`: start bit, data bits, optional parity bit, then stop bit(s).
- It sits between user logic and the FPGA TX pin, for example to echo received bytes back or to send status.

Parameters:
- BAUD_DIV, 434, clock cycles per bit (>=2); 1250 on iCEBreaker at 12 MHz / 9600 baud.
- DATA_BITS, 8, data bits per frame (5..9).
- PARITY_TYPE, 0, 0 = none, 1 = even, 2 = odd; any other value is treated as none.
- STOP_BIT, 1, number of stop bits (1..2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- tx_valid  input  1  data_in holds a word to send.
- data_in  input  DATA_BITS  word to transmit.
- tx_ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line; idle high; registered.
- busy  output  1  a frame is on the line.
- tx_done  output  1  one-cycle pulse when the last stop bit period ends.

Behaviour:
- Reset values (applied immediately, async): tx=1, tx_ready=1, busy=0, tx_done=0, state=IDLE, all counters 0, shift/holding registers 0.
- Reset asserted mid-frame: the frame is aborted, tx returns high at once, and nothing resumes after release.
- Accept rule: a word is taken at any rising edge where tx_valid && tx_ready. data_in is latched into the shift register at that edge. Later changes on data_in do not affect the frame.
- Parity is computed from the latched word: even → ^data; odd → ~^data.
- FSM states IDLE, START, DATA, PARITY, STOP; all are updated only on clk edges.
  - IDLE: tx=1. On accept → START. At that same edge: tx<=0, busy<=1, tx_ready<=0, baud counter<=0.
  - Baud counter counts 0..BAUD_DIV-1 within each bit. Every bit, including the start bit, is exactly BAUD_DIV cycles; there is no half-bit offset.
  - At the baud wrap the FSM advances:
    - START → DATA, with tx<=bit0.
    - DATA shifts LSB-first. After bit DATA_BITS-1 it goes to PARITY (PARITY_TYPE 1 or 2) or to STOP.
    - PARITY: tx<=parity bit, then → STOP.
    - STOP: tx<=1 for STOP_BIT bit periods, counted by stop_counter.
  - At the wrap of the last stop period → IDLE. At that edge tx_done<=1 for one cycle, busy<=0, tx_ready<=1.
- Frame length: N = 1 + DATA_BITS + (parity ? 1 : 0) + STOP_BIT bits, which is N*BAUD_DIV cycles from the accept edge to the tx_done edge.
- Back-to-back frames: the minimum gap is one idle cycle. tx_ready rises at the tx_done edge, and the next accept happens on the following edge.
- tx_valid held high while tx_ready=0 is ignored. No word is lost or duplicated; the word is taken at the first edge where tx_ready=1.
- Counter widths:
  - baud counter: $clog2(BAUD_DIV) bits.
  - bit counter: $clog2(DATA_BITS)+1 bits.
  - Neither counter wraps except at its terminal count.

Optional Feature:
- Macro: UART_TX_BUF_EN.
- Defined: adds a one-entry holding register in front of the shift register.
  - tx_ready = holding register empty, so a word can be accepted while a frame is in progress.
  - At the last stop-bit wrap, if the holding register is full, its word moves to the shift register and a start bit is driven at that same edge. The gap between frames is zero cycles.
  - tx_done still pulses for every frame.
  - On reset the holding register is emptied.
- Undefined: no holding register. tx_ready is low throughout the frame, as described in Behaviour.

Test Plan:
- Idle after reset (BAUD_DIV=4): hold rst_n low 3 cycles, then release → tx=1, tx_ready=1, busy=0, and no tx_done for 100 cycles.
- 8N1, data_in=8'hA5, BAUD_DIV=4:
  - tx sequence sampled mid-bit = 0,1,0,1,0,0,1,0,1,1.
  - tx_done arrives exactly 40 cycles after the accept edge.
- PARITY_TYPE=1, data 8'h07 → parity bit 1; PARITY_TYPE=2, data 8'h07 → parity bit 0. Frame length is 11*BAUD_DIV cycles in both cases.
- STOP_BIT=2, data 8'h00 → tx low for 9*BAUD_DIV cycles, then high for 2*BAUD_DIV cycles; tx_done at 11*BAUD_DIV.
- tx_valid held high with data changing every cycle:
  - Only words sampled at tx_ready=1 edges are sent.
  - Without UART_TX_BUF_EN there is a 1-cycle idle gap between frames.
  - With UART_TX_BUF_EN the gap is 0 cycles.
- rst_n pulsed low during bit 3 of a frame → tx=1 immediately and tx_ready=1. Then send 8'h3C → it is received correctly by the uart_rx loopback model.
